dm_lane_unit: RTL and testbench

DM_LANE_UNIT -- requirements
Module: dm_lane_unit

---
 rtl/dm_lane_unit.sv | 183 ++++++++++++++++++
 tb/tb_dm_lane_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dm_lane_unit.sv
// Load/store lane unit: aligns CPU byte/half/word/dword accesses onto a DATA_W memory
// port, checks alignment, waits for mem_ack with a timeout and returns an extended load result.
module dm_lane_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_wm,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] WM_WD = 3'd0;
  localparam logic [2:0] WM_HU = 3'd1;
  localparam logic [2:0] WM_HS = 3'd2;
  localparam logic [2:0] WM_BU = 3'd3;
  localparam logic [2:0] WM_BS = 3'd4;
  localparam logic [2:0] WM_DW = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_wm;
  logic [OFF_W-1:0]   r_off;

  logic [OFF_W-1:0]   w_off;
  logic               w_legal;
  logic [BE_W-1:0]    w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic [ADDR_W-1:0]  w_mem_addr;

  // Extend a lane-shifted load word according to the access mode; word loads sign-extend on 64-bit.
  function automatic logic [DATA_W-1:0] ext_load(input logic [2:0] wm, input logic [DATA_W-1:0] b);
    ext_load = '0;
    case (wm)
      WM_BS:   ext_load = DATA_W'($signed(b[7:0]));
      WM_BU:   ext_load = DATA_W'(b[7:0]);
      WM_HS:   ext_load = DATA_W'($signed(b[15:0]));
      WM_HU:   ext_load = DATA_W'(b[15:0]);
      WM_WD:   ext_load = (DATA_W == 64) ? DATA_W'($signed(b[31:0])) : DATA_W'(b[31:0]);
      WM_DW:   ext_load = b;
      default: ext_load = '0;
    endcase
  endfunction

  assign w_off      = req_addr[OFF_W-1:0];
  assign w_wdata    = req_wdata << {w_off, 3'b000};
  assign w_mem_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Legality check and byte-enable generation for the incoming request.
  always_comb begin
    w_legal = 1'b0;
    w_be    = '0;
    case (req_wm)
      WM_BU, WM_BS: begin
        w_legal = 1'b1;
        w_be    = BE_W'(1'b1) << w_off;
      end
      WM_HU, WM_HS: begin
        w_legal = (req_addr[0] == 1'b0);
        w_be    = BE_W'(2'b11) << w_off;
      end
      WM_WD: begin
        w_legal = (req_addr[1:0] == 2'b00);
        w_be    = BE_W'(4'hF) << w_off;
      end
      WM_DW: begin
        w_legal = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
        w_be    = {BE_W{1'b1}};
      end
      default: begin
        w_legal = 1'b0;
        w_be    = '0;
      end
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_wm      <= 3'd0;
      r_off     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_wm      <= req_wm;
            r_off     <= w_off;
            r_cnt     <= '0;
            req_ready <= 1'b0;
            if (w_legal) begin
              r_state   <= S_ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= w_mem_addr;
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end else begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_ACCESS: begin
          // An ack on the last permitted cycle still wins over the timeout.
          if (mem_ack) begin
            r_state   <= S_RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? '0 : ext_load(r_wm, mem_rdata >> {r_off, 3'b000});
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state   <= S_RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lane_unit.sv
// Directed, table-driven bench for dm_lane_unit (DATA_W=32, TIMEOUT=4), plus reset
// and stray-ack sequences.
module tb_dm_lane_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  localparam logic [2:0] WD = 3'd0, HU = 3'd1, HS = 3'd2, BU = 3'd3, BS = 3'd4, DWM = 3'd5;

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_wm;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dm_lane_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wm(req_wm),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack;     // ACCESS cycle (1-based) carrying mem_ack; 0 = never
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] maddr;
    logic        err;
    logic [31:0] exp_rd;
    int          en;      // expected number of mem_en cycles
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] wm, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                              input logic [3:0] be, input logic [31:0] exp_wd,
                              input logic [31:0] maddr, input logic err,
                              input logic [31:0] exp_rd, input int en);
    vec_t v;
    v.we = we; v.wm = wm; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack = ack;
    v.be = be; v.exp_wd = exp_wd; v.maddr = maddr; v.err = err; v.exp_rd = exp_rd; v.en = en;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int          steps;
    int          en_cnt;
    logic        seen;
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{v.be[i]}};
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_wm = v.wm; req_addr = v.addr; req_wdata = v.wdata;
    steps = 0; en_cnt = 0; seen = 1'b0;
    while (!seen && steps < 12) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      steps++;
      if (mem_en) begin
        en_cnt++;
        chk($sformatf("v%0d_c%0d_be", idx, en_cnt), {28'd0, mem_be}, {28'd0, v.be});
        chk($sformatf("v%0d_c%0d_addr", idx, en_cnt), mem_addr, v.maddr);
        chk($sformatf("v%0d_c%0d_wdata", idx, en_cnt), mem_wdata & mask, v.exp_wd & mask);
        chk($sformatf("v%0d_c%0d_we", idx, en_cnt), {31'd0, mem_we}, {31'd0, v.we});
        if (en_cnt == v.ack) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (rsp_valid) seen = 1'b1;
    end
    mem_ack = 1'b0;
    chk($sformatf("v%0d_rsp_seen", idx), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d_en_cycles", idx), en_cnt, v.en);
    chk($sformatf("v%0d_latency", idx), steps, 1 + v.en);
    chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rd);
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", idx), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    //            we    wm   addr   wdata        rdata       ack be      exp_wd       maddr  err  exp_rd       en
    vecs[0]  = mk(1'b1, BU,  32'h13, 32'h000000AB, 32'h0,        1, 4'b1000, 32'hAB000000, 32'h10, 1'b0, 32'h0,        1);
    vecs[1]  = mk(1'b0, HS,  32'h02, 32'h0,        32'h80011234, 1, 4'b1100, 32'h0,        32'h00, 1'b0, 32'hFFFF8001, 1);
    vecs[2]  = mk(1'b0, HU,  32'h02, 32'h0,        32'h80011234, 1, 4'b1100, 32'h0,        32'h00, 1'b0, 32'h00008001, 1);
    vecs[3]  = mk(1'b0, BS,  32'h01, 32'h0,        32'h00007F00, 1, 4'b0010, 32'h0,        32'h00, 1'b0, 32'h0000007F, 1);
    vecs[4]  = mk(1'b0, BS,  32'h01, 32'h0,        32'h00008000, 1, 4'b0010, 32'h0,        32'h00, 1'b0, 32'hFFFFFF80, 1);
    vecs[5]  = mk(1'b0, WD,  32'h06, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h00, 1'b1, 32'h0,        0);
    vecs[6]  = mk(1'b0, DWM, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h00, 1'b1, 32'h0,        0);
    vecs[7]  = mk(1'b0, WD,  32'h08, 32'h0,        32'hDEADBEEF, 2, 4'b1111, 32'h0,        32'h08, 1'b0, 32'hDEADBEEF, 2);
    vecs[8]  = mk(1'b1, HU,  32'h22, 32'h00001234, 32'hFFFFFFFF, 3, 4'b1100, 32'h12340000, 32'h20, 1'b0, 32'h0,        3);
    vecs[9]  = mk(1'b0, BU,  32'h03, 32'h0,        32'h9A000000, 1, 4'b1000, 32'h0,        32'h00, 1'b0, 32'h0000009A, 1);
    vecs[10] = mk(1'b0, BU,  32'h00, 32'h0,        32'h0,        0, 4'b0001, 32'h0,        32'h00, 1'b1, 32'h0,        4);
    vecs[11] = mk(1'b0, WD,  32'h04, 32'h0,        32'h12345678, 4, 4'b1111, 32'h0,        32'h04, 1'b0, 32'h12345678, 4);
    vecs[12] = mk(1'b0, HS,  32'h01, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h00, 1'b1, 32'h0,        0);
    vecs[13] = mk(1'b0, 3'd6, 32'h00, 32'h0,       32'h0,        1, 4'b0000, 32'h0,        32'h00, 1'b1, 32'h0,        0);
    vecs[14] = mk(1'b1, 3'd7, 32'h00, 32'h55,      32'h0,        1, 4'b0000, 32'h0,        32'h00, 1'b1, 32'h0,        0);
    vecs[15] = mk(1'b1, WD,  32'h0C, 32'hCAFEBABE, 32'h0,        1, 4'b1111, 32'hCAFEBABE, 32'h0C, 1'b0, 32'h0,        1);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wm = 3'd0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Stray acks while idle must not start or complete anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);
    end
    mem_ack = 1'b0;

    // Reset in the middle of ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_wm = BU; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_access_en", {31'd0, mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_hold_rsp", {31'd0, rsp_valid}, 32'd0);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rel_en", {31'd0, mem_en}, 32'd0);
    run_vec(16, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
